// File: rtl/register_snapshot_reader.sv
// Captures a bank of COUNT SIZE-bit words on a start strobe and streams them
// out lowest index first over a valid/ready handshake. All outputs registered.
module register_snapshot_reader #(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned COUNT      = 4,
    parameter int unsigned INDEX_BITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SIZE*COUNT-1:0] d,
    input  logic                  start,
    input  logic                  ready,
    output logic [SIZE-1:0]       q,
    output logic                  valid,
    output logic [INDEX_BITS-1:0] index,
    output logic                  last,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                state;
    logic [SIZE-1:0]       snap [COUNT];
    logic [INDEX_BITS-1:0] next_index;
    logic [SIZE-1:0]       next_word;
    logic                  capture;

    assign capture = (state == StIdle) && start;

    always_comb begin
        next_index = index + 1'b1;
        next_word  = '0;
        for (int i = 0; i < int'(COUNT); i++) begin
            if (next_index == INDEX_BITS'(i)) begin
                next_word = snap[i];
            end
        end
    end

    // Snapshot contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int i = 0; i < int'(COUNT); i++) begin
                snap[i] <= d[i*SIZE +: SIZE];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= StIdle;
            q     <= '0;
            valid <= 1'b0;
            index <= '0;
            last  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= StStream;
                        q     <= d[SIZE-1:0];
                        valid <= 1'b1;
                        index <= '0;
                        last  <= (COUNT == 1);
                        busy  <= 1'b1;
                    end
                end
                StStream: begin
                    if (ready) begin
                        if (last) begin
                            // q keeps the final word after the stream ends.
                            state <= StIdle;
                            valid <= 1'b0;
                            index <= '0;
                            last  <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            q     <= next_word;
                            index <= next_index;
                            last  <= (next_index == INDEX_BITS'(COUNT - 1));
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_snapshot_reader.sv
// Directed and randomized checks of register_snapshot_reader against a
// word-queue reference model; a second instance covers COUNT=1.
module tb_register_snapshot_reader;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned COUNT = 4;
    localparam int unsigned IB    = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [SIZE*COUNT-1:0] d;
    logic                  start;
    logic                  ready;
    logic [SIZE-1:0]       q;
    logic                  valid;
    logic [IB-1:0]         index;
    logic                  last;
    logic                  busy;

    logic [SIZE-1:0]       d1;
    logic                  start1;
    logic                  ready1;
    logic [SIZE-1:0]       q1;
    logic                  valid1;
    logic [0:0]            index1;
    logic                  last1;
    logic                  busy1;

    int checks = 0;
    int errors = 0;

    // Reference model: captured words plus a read position.
    logic [SIZE-1:0] m_snap [COUNT];
    logic [SIZE-1:0] m_q;
    int              m_pos;
    bit              m_stream;

    logic [SIZE-1:0] exp_words [4];
    logic [SIZE-1:0] seen [$];
    bit              pat [4];
    logic [SIZE-1:0] w0;

    register_snapshot_reader #(.SIZE(SIZE), .COUNT(COUNT), .INDEX_BITS(IB)) dut (
        .clock(clock), .reset(reset), .d(d), .start(start), .ready(ready),
        .q(q), .valid(valid), .index(index), .last(last), .busy(busy)
    );

    register_snapshot_reader #(.SIZE(SIZE), .COUNT(1), .INDEX_BITS(1)) dut1 (
        .clock(clock), .reset(reset), .d(d1), .start(start1), .ready(ready1),
        .q(q1), .valid(valid1), .index(index1), .last(last1), .busy(busy1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_stream = 0;
            m_pos    = 0;
            m_q      = '0;
        end else if (!m_stream) begin
            if (start) begin
                for (int i = 0; i < int'(COUNT); i++) m_snap[i] = d[i*SIZE +: SIZE];
                m_pos    = 0;
                m_q      = m_snap[0];
                m_stream = 1;
            end
        end else if (ready) begin
            if (m_pos == int'(COUNT) - 1) begin
                m_stream = 0;
                m_pos    = 0;
            end else begin
                m_pos = m_pos + 1;
                m_q   = m_snap[m_pos];
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_update();
        #1;
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".valid"}, 32'(valid), 32'(m_stream));
        chk({tag, ".busy"}, 32'(busy), 32'(m_stream));
        chk({tag, ".index"}, 32'(index), 32'(m_pos));
        chk({tag, ".last"}, 32'(last), 32'(m_stream && (m_pos == int'(COUNT) - 1)));
    endtask

    task automatic drain();
        start = 0;
        ready = 1;
        for (int i = 0; i < 20; i++) begin
            if (!m_stream) break;
            step("drain");
        end
        chk("drain.idle", 32'(valid), 32'd0);
    endtask

    initial begin
        exp_words[0] = 8'h11; exp_words[1] = 8'h22;
        exp_words[2] = 8'h33; exp_words[3] = 8'h44;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        m_stream = 0; m_pos = 0; m_q = '0;
        reset = 1; start = 0; ready = 0; d = '0;
        d1 = '0; start1 = 0; ready1 = 0;

        // Reset state
        step("rst");
        step("rst");
        chk("rst.q", 32'(q), 32'h00);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.index", 32'(index), 32'd0);
        chk("rst.last", 32'(last), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst1.valid", 32'(valid1), 32'd0);
        chk("rst1.q", 32'(q1), 32'h00);

        // Idle hold for 10 cycles
        reset = 0;
        for (int i = 0; i < 10; i++) step("idle");
        chk("idle.q", 32'(q), 32'h00);
        chk("idle.busy", 32'(busy), 32'd0);

        // Full-rate stream
        d = 32'h44332211; start = 1; ready = 1;
        step("fr.start");
        start = 0;
        for (int k = 0; k < 4; k++) begin
            chk("fr.word", 32'(q), 32'(exp_words[k]));
            chk("fr.index", 32'(index), 32'(k));
            chk("fr.last", 32'(last), 32'(k == 3));
            chk("fr.valid", 32'(valid), 32'd1);
            step("fr");
        end
        chk("fr.end.valid", 32'(valid), 32'd0);
        chk("fr.end.busy", 32'(busy), 32'd0);
        chk("fr.end.q", 32'(q), 32'h44);

        // Ready toggling, d overwritten after capture
        d = 32'h44332211; start = 1; ready = 1;
        step("rt.start");
        start = 0;
        d = 32'hFFFFFFFF;
        seen.delete();
        for (int i = 0; i < 40; i++) begin
            if (!m_stream) break;
            ready = pat[i % 4];
            #1;
            if (valid && ready) seen.push_back(q);
            step("rt");
        end
        chk("rt.done", 32'(valid), 32'd0);
        chk("rt.count", 32'(seen.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < seen.size()) chk("rt.word", 32'(seen[k]), 32'(exp_words[k]));
            else chk("rt.word", 32'hDEAD, 32'(exp_words[k]));
        end

        // start held high: one idle cycle between streams
        d = 32'h0D0C0B0A; start = 1; ready = 1;
        for (int k = 0; k < 10; k++) begin
            step("hold");
            chk("hold.valid", 32'(valid), 32'((k % 5) != 4));
        end
        drain();

        // Reset mid-stream at index 2
        d = 32'h87654321; start = 1; ready = 1;
        step("ab.start");
        start = 0;
        step("ab");
        step("ab");
        chk("ab.index2", 32'(index), 32'd2);
        reset = 1;
        step("ab.rst");
        chk("ab.rst.q", 32'(q), 32'h00);
        chk("ab.rst.valid", 32'(valid), 32'd0);
        chk("ab.rst.busy", 32'(busy), 32'd0);
        chk("ab.rst.index", 32'(index), 32'd0);
        reset = 0;
        d = 32'h5A6B7C8D; start = 1;
        w0 = 8'h8D;
        step("ab.restart");
        start = 0;
        chk("ab.restart.index", 32'(index), 32'd0);
        chk("ab.restart.q", 32'(q), 32'(w0));
        drain();

        // COUNT=1 instance
        d1 = 8'hA5; start1 = 1; ready1 = 0;
        step("c1.start");
        start1 = 0;
        d1 = 8'h00;
        chk("c1.q", 32'(q1), 32'hA5);
        chk("c1.last", 32'(last1), 32'd1);
        chk("c1.index", 32'(index1), 32'd0);
        chk("c1.valid", 32'(valid1), 32'd1);
        step("c1.wait");
        chk("c1.hold.valid", 32'(valid1), 32'd1);
        chk("c1.hold.q", 32'(q1), 32'hA5);
        ready1 = 1;
        step("c1.hs");
        chk("c1.end.valid", 32'(valid1), 32'd0);
        chk("c1.end.busy", 32'(busy1), 32'd0);
        chk("c1.end.last", 32'(last1), 32'd0);
        chk("c1.end.q", 32'(q1), 32'hA5);
        ready1 = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            d     = $urandom;
            start = ($urandom_range(0, 1) == 1);
            ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 49) == 0);
            step("rnd");
        end
        reset = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_snapshot_reader.md
# register_snapshot_reader

Read-side companion to the generic write-enabled register. It captures a bank of COUNT parallel SIZE-bit register values on a single `start` strobe. It then streams them out one word per transfer over a valid/ready handshake, lowest index first. It sits between a register bank and a narrower consumer, such as a debug or readback bus, so the whole bank is observed as one coherent snapshot.

## Interface
- SIZE, 8: bit width of each word.
- COUNT, 4: number of words in the bank; legal range is 1 or more.
- INDEX_BITS, 2: width of `index`; must satisfy 2^INDEX_BITS >= COUNT.
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; has priority over every other input.
- d  input  SIZE*COUNT  register bank contents; word i = d[i*SIZE +: SIZE].
- start  input  1  request a snapshot and stream.
- ready  input  1  consumer accepts the current word.
- q  output  SIZE  current output word.
- valid  output  1  `q`, `index` and `last` are meaningful.
- index  output  INDEX_BITS  bank index of the word on `q`.
- last  output  1  the word on `q` is word COUNT-1.
- busy  output  1  a stream is in progress; `start` is ignored.

## Operation
- Internal storage holds a snapshot of COUNT×SIZE bits. It is written only when `start` is accepted.
- FSM states:
  - IDLE: `valid`=0, `busy`=0.
  - STREAM: `valid`=1, `busy`=1.
- Reset (reset=1 at an edge): state→IDLE; q=0, valid=0, index=0, last=0, busy=0.
  - The snapshot contents are don't-care after reset.
  - A reset during STREAM aborts the stream immediately. The partial stream is not resumed.
- IDLE, start=1:
  - Copy all of `d` into the snapshot.
  - Set index=0 and q=word 0.
  - Set last=(COUNT==1).
  - Move to STREAM.
- IDLE, start=0: all outputs hold. `q` keeps the last transferred word.
- STREAM, valid&ready, index<COUNT-1:
  - index+1 → index.
  - q=snapshot word index+1.
  - last=(index+1==COUNT-1).
- STREAM, valid&ready, index==COUNT-1 (last=1):
  - Move to IDLE; valid=0, busy=0, last=0.
  - index resets to 0. `q` holds.
- STREAM, ready=0: q, index and last are held stable (standard no-retract handshake).
- `start` in STREAM is ignored, including in the same cycle as the final handshake.
- Changes on `d` after capture never affect the words being streamed.
- `index` never exceeds COUNT-1. No wrap-around occurs within a stream.

## Timing
- `start` sampled at edge N → valid=1 and q=word 0 from edge N (visible in cycle N+1).
- Each handshake at an edge presents the next word in the following cycle. Throughput is one word per cycle while ready=1.
- With ready held at 1, a full stream occupies exactly COUNT cycles with valid=1.
- After the final handshake, valid=0 for at least one cycle.
  - The earliest accepted next `start` is the cycle after the final handshake.
  - Minimum start-to-start period is therefore COUNT+1 cycles.
- There is no combinational path from `ready` or `start` to any output. All outputs are registered.

## Test plan
- Reset then idle, with SIZE=8, COUNT=4 → q=0x00, valid=0, index=0, last=0, busy=0. Outputs are unchanged for 10 cycles with start=0.
- d={0x44,0x33,0x22,0x11} (word 0 = 0x11), pulse start, ready=1 → q=0x11,0x22,0x33,0x44 on 4 consecutive cycles. index runs 0..3, last=1 only with 0x44, then valid=0 and busy=0.
- Same stream with ready toggling 1,0,0,1,… and d changed to all 0xFF right after start → words are still 0x11..0x44 in order. q and index are held during every ready=0 cycle.
- start held high through a whole stream → no restart mid-stream. A new capture occurs in the first IDLE cycle, and valid stays low for exactly one cycle between streams.
- Assert reset while index=2 → next cycle shows q=0, valid=0, busy=0, index=0. A subsequent start streams from word 0.
- COUNT=1, d=0xA5, start → a single word 0xA5 with last=1 and index=0. The block returns to IDLE after one handshake.
